timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter BIT_SIZE, default 8, the width of the controlled counter register.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port mode, input, 1 bit: 0 selects count-up stopwatch, 1 selects count-down timer; sampled only at start.
REQ-005 SHALL have port start_stop, input, 1 bit: single-cycle pulse that starts, pauses or resumes counting.
REQ-006 SHALL have port clear, input, 1 bit: single-cycle pulse that aborts and returns to IDLE.
REQ-007 SHALL have port tick, input, 1 bit: count-enable pulse, one count step per asserted cycle.
REQ-008 SHALL have port load_val, input, BIT_SIZE bits: down-mode start value and up-mode terminal limit.
REQ-009 SHALL have port cnt_q, input, BIT_SIZE bits: the current counter register output.
REQ-010 SHALL have port cnt_d, output, BIT_SIZE bits: next value for the counter register, which loads it every clk.
REQ-011 SHALL have port cnt_rst_val, output, BIT_SIZE bits: counter register reset value, equal to preset.
REQ-012 SHALL have ports running, paused and done, each output, 1 bit, registered, one-hot decodes of RUN, PAUSE and DONE.
REQ-013 SHALL have port done_pulse, output, 1 bit, registered: high for exactly one cycle on entry to DONE.

Function
REQ-014 SHALL define preset as load_val when mode=1 and 0 when mode=0, taken combinationally from the current inputs.
REQ-015 SHALL implement a four-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-016 In IDLE: cnt_d = preset; on start_stop, mode_q <= mode; go to RUN, or to DONE if mode=1 and load_val=0.
REQ-017 In RUN, tick=0: cnt_d = cnt_q (hold).
REQ-018 In RUN, tick=1, mode_q=0: cnt_d = cnt_q+1 modulo 2^BIT_SIZE; if load_val!=0 and cnt_q+1 == load_val, go to DONE.
REQ-019 In RUN, up mode with load_val=0: free-run, wrapping 2^BIT_SIZE-1 -> 0, never entering DONE.
REQ-020 In RUN, tick=1, mode_q=1: cnt_d = cnt_q-1; if cnt_q == 1, go to DONE; if cnt_q == 0, cnt_d = 0 and go to DONE (no underflow wrap).
REQ-021 In RUN, start_stop goes to PAUSE; a tick in the same cycle is still applied, and a terminal tick in the same cycle goes to DONE instead.
REQ-022 In PAUSE: cnt_d = cnt_q and tick is ignored; start_stop returns to RUN.
REQ-023 In DONE: cnt_d = cnt_q (final value held); start_stop and tick are ignored; only clear or reset leave the state.
REQ-024 clear in any state goes to IDLE with cnt_d = preset in the same cycle; clear has priority over start_stop and tick.
REQ-025 Changes to mode or load_val while in RUN, PAUSE or DONE SHALL NOT change the count direction; load_val changes affect only the terminal compare.
REQ-026 Latency: cnt_q reflects cnt_d one clk later; status outputs update on the same edge as the state.

Reset
REQ-027 While rst_n=0 at a clk edge: state <= IDLE, mode_q <= 0, running = paused = done = done_pulse = 0.
REQ-028 During reset, cnt_d SHALL equal preset, so cnt_q settles to preset at the first edge after reset.
REQ-029 Reset in the middle of RUN or PAUSE SHALL discard progress identically to clear.

Verification
REQ-030 Up mode, BIT_SIZE=8, load_val=5, start, 5 ticks -> cnt_q 1,2,3,4,5; done=1 and a single done_pulse after the 5th tick; further ticks leave 5.
REQ-031 Down mode, load_val=8'h9A, start, 3 ticks, start_stop, 4 ticks, start_stop, 1 tick -> cnt_q 0x97 held while paused, then 0x96, running=1.
REQ-032 Down mode, load_val=0, start -> DONE next cycle; cnt_q=0; done_pulse once.
REQ-033 Up mode, load_val=0, from 0xFE, 3 ticks -> 0xFF, 0x00, 0x01; done stays 0.
REQ-034 RUN with clear+start_stop+tick in the same cycle -> IDLE, cnt_q = preset next cycle, running=0.
REQ-035 rst_n=0 for 1 cycle during RUN at 0x40, mode=1, load_val=0x10 -> IDLE, cnt_q=0x10, all status outputs 0.

Source files
------------

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - stopwatch / countdown controller driving an external counter register
//
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   mode          0 = count-up stopwatch, 1 = count-down timer (captured at start)
//   start_stop    pulse: start from IDLE, pause from RUN, resume from PAUSE
//   clear         pulse: abort to IDLE and reload the preset
//   tick          count enable, one step per asserted cycle while running
//   load_val      down-mode start value / up-mode terminal limit (0 = free-run)
//   cnt_q         current value of the external counter register
//   cnt_d         next value for the external counter register
//   cnt_rst_val   reset value for the external counter register (the preset)
//   running, paused, done   registered one-hot state decodes
//   done_pulse    registered, high for one cycle on entry to DONE
module timer_ctrl #(
    parameter int BIT_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                tick,
    input  logic [BIT_SIZE-1:0] load_val,
    input  logic [BIT_SIZE-1:0] cnt_q,
    output logic [BIT_SIZE-1:0] cnt_d,
    output logic [BIT_SIZE-1:0] cnt_rst_val,
    output logic                running,
    output logic                paused,
    output logic                done,
    output logic                done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [BIT_SIZE-1:0] CNT_ZERO = '0;
    localparam logic [BIT_SIZE-1:0] CNT_ONE  = {{(BIT_SIZE-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic                mode_q;
    logic [BIT_SIZE-1:0] preset;
    logic [BIT_SIZE-1:0] cnt_inc;
    logic [BIT_SIZE-1:0] cnt_dec;
    logic                terminal;

    assign preset      = mode ? load_val : CNT_ZERO;
    assign cnt_rst_val = preset;
    assign cnt_inc     = cnt_q + CNT_ONE;
    assign cnt_dec     = cnt_q - CNT_ONE;

    // Terminal detection for a tick applied this cycle, using the direction
    // latched at start; load_val only moves the up-mode limit.
    always_comb begin
        terminal = 1'b0;
        if (mode_q) begin
            terminal = (cnt_q == CNT_ONE) || (cnt_q == CNT_ZERO);
        end else begin
            terminal = (load_val != CNT_ZERO) && (cnt_inc == load_val);
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        state_nxt = state;
        if (!rst_n || clear) begin
            cnt_d     = preset;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_d = preset;
                    if (start_stop) begin
                        state_nxt = (mode && load_val == CNT_ZERO) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (mode_q) begin
                            // Saturate at zero instead of wrapping.
                            cnt_d = (cnt_q == CNT_ZERO) ? CNT_ZERO : cnt_dec;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    // A terminal tick wins over a simultaneous pause request.
                    if (tick && terminal) begin
                        state_nxt = S_DONE;
                    end else if (start_stop) begin
                        state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            running    <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (state == S_IDLE && start_stop && !clear) begin
                mode_q <= mode;
            end
            running    <= (state_nxt == S_RUN);
            paused     <= (state_nxt == S_PAUSE);
            done       <= (state_nxt == S_DONE);
            done_pulse <= (state_nxt == S_DONE) && (state != S_DONE);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl
module tb_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       start_stop;
    logic       clear;
    logic       tick;
    logic [7:0] load_val;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_rst_val;
    logic       running;
    logic       paused;
    logic       done;
    logic       done_pulse;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Behavioural model: phase name, counter value, latched direction.
    localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;
    int m_phase = P_IDLE;
    int m_cnt   = 0;
    int m_down  = 0;
    int m_pulse = 0;

    timer_ctrl #(.BIT_SIZE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .start_stop (start_stop),
        .clear      (clear),
        .tick       (tick),
        .load_val   (load_val),
        .cnt_q      (cnt_q),
        .cnt_d      (cnt_d),
        .cnt_rst_val(cnt_rst_val),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .done_pulse (done_pulse)
    );

    // External counter register loaded from cnt_d every edge.
    always_ff @(posedge clk) cnt_q <= cnt_d;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs held during that cycle.
    task automatic model_update();
        int preset;
        int lv;
        bit fin;
        lv     = int'(load_val);
        preset = mode ? lv : 0;
        m_pulse = 0;
        if (!rst_n || clear) begin
            m_phase = P_IDLE;
            m_cnt   = preset;
            if (!rst_n) m_down = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    m_cnt = preset;
                    if (start_stop) begin
                        m_down = mode;
                        if (mode && lv == 0) begin
                            m_phase = P_DONE;
                            m_pulse = 1;
                        end else begin
                            m_phase = P_RUN;
                        end
                    end
                end
                P_RUN: begin
                    fin = 0;
                    if (tick) begin
                        if (m_down != 0) begin
                            fin   = (m_cnt <= 1);
                            m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
                        end else begin
                            m_cnt = (m_cnt + 1) % 256;
                            fin   = (lv != 0) && (m_cnt == lv);
                        end
                    end
                    if (fin) begin
                        m_phase = P_DONE;
                        m_pulse = 1;
                    end else if (start_stop) begin
                        m_phase = P_PAUSE;
                    end
                end
                P_PAUSE: if (start_stop) m_phase = P_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit md, input bit ss, input bit cl,
                        input bit tk, input logic [7:0] lv);
        rst_n      = r;
        mode       = md;
        start_stop = ss;
        clear      = cl;
        tick       = tk;
        load_val   = lv;
        @(posedge clk);
        #1;
        model_update();
        chk_en = 1;
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cnt_q", int'(cnt_q), m_cnt);
            check("running", int'(running), int'(m_phase == P_RUN));
            check("paused", int'(paused), int'(m_phase == P_PAUSE));
            check("done", int'(done), int'(m_phase == P_DONE));
            check("done_pulse", int'(done_pulse), m_pulse);
            check("cnt_rst_val", int'(cnt_rst_val), mode ? int'(load_val) : 0);
        end
    end

    initial begin
        rst_n = 0; mode = 0; start_stop = 0; clear = 0; tick = 0; load_val = 0;

        // Reset state.
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("lit_reset_cnt", int'(cnt_q), 0);
        check("lit_reset_status", int'({running, paused, done, done_pulse}), 0);

        // Up mode to limit 5.
        step(1, 0, 1, 0, 0, 8'd5);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 0, 1, 8'd5);
            check("lit_up_cnt", int'(cnt_q), i);
        end
        check("lit_up_done", int'(done), 1);
        check("lit_up_pulse", int'(done_pulse), 1);
        step(1, 0, 1, 0, 1, 8'd5);
        step(1, 0, 0, 0, 1, 8'd5);
        check("lit_up_hold", int'(cnt_q), 5);
        check("lit_up_pulse_once", int'(done_pulse), 0);
        step(1, 0, 0, 1, 0, 8'd5);

        // Down mode with pause.
        step(1, 1, 1, 0, 0, 8'h9A);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 8'h9A);
        step(1, 1, 1, 0, 0, 8'h9A);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 8'h9A);
        check("lit_pause_hold", int'(cnt_q), 8'h97);
        check("lit_paused", int'(paused), 1);
        step(1, 1, 1, 0, 0, 8'h9A);
        step(1, 1, 0, 0, 1, 8'h9A);
        check("lit_resume_cnt", int'(cnt_q), 8'h96);
        check("lit_resume_run", int'(running), 1);
        step(1, 1, 0, 1, 0, 8'h00);

        // Down mode from zero: straight to DONE.
        step(1, 1, 1, 0, 0, 8'h00);
        check("lit_zero_done", int'(done), 1);
        check("lit_zero_cnt", int'(cnt_q), 0);
        check("lit_zero_pulse", int'(done_pulse), 1);
        step(1, 1, 0, 0, 1, 8'h00);
        check("lit_zero_pulse_once", int'(done_pulse), 0);
        step(1, 0, 0, 1, 0, 8'h00);

        // Up free-run wrap.
        step(1, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 254; i++) step(1, 0, 0, 0, 1, 8'h00);
        check("lit_wrap_fe", int'(cnt_q), 8'hFE);
        step(1, 0, 0, 0, 1, 8'h00);
        check("lit_wrap_ff", int'(cnt_q), 8'hFF);
        step(1, 0, 0, 0, 1, 8'h00);
        check("lit_wrap_00", int'(cnt_q), 8'h00);
        step(1, 0, 0, 0, 1, 8'h00);
        check("lit_wrap_01", int'(cnt_q), 8'h01);
        check("lit_wrap_not_done", int'(done), 0);

        // Mode flips mid-run must not change direction; then clear wins.
        step(1, 1, 0, 0, 1, 8'h33);
        check("lit_dir_kept", int'(cnt_q), 8'h02);
        step(1, 1, 1, 1, 1, 8'h33);
        check("lit_clear_cnt", int'(cnt_q), 8'h33);
        check("lit_clear_run", int'(running), 0);

        // Reset mid-run discards progress.
        step(1, 1, 1, 0, 0, 8'h40);
        step(1, 1, 0, 0, 0, 8'h10);
        step(0, 1, 0, 0, 1, 8'h10);
        check("lit_rst_cnt", int'(cnt_q), 8'h10);
        check("lit_rst_status", int'({running, paused, done, done_pulse}), 0);

        // Terminal tick together with pause goes to DONE; DONE ignores inputs.
        step(1, 1, 1, 0, 0, 8'h02);
        step(1, 1, 0, 0, 1, 8'h02);
        step(1, 1, 1, 0, 1, 8'h02);
        check("lit_term_done", int'(done), 1);
        check("lit_term_cnt", int'(cnt_q), 0);
        step(1, 1, 1, 0, 1, 8'h02);
        step(1, 1, 0, 0, 1, 8'h02);
        check("lit_done_sticky", int'(done), 1);
        step(1, 0, 0, 1, 0, 8'h02);
        step(1, 0, 0, 0, 0, 8'h02);

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
